// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite register bank:
//   - 1-bit response encodings (OKAY / SLVERR)
//   - write and read handshake FSM state encodings
//   - address decode helper returning the word index and a decode-error flag
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } r_state_t;

    typedef struct packed {
        logic [29:0] index;  // word index = byte address >> 2
        logic        err;    // misaligned or beyond the register bank
    } addr_decode_t;

    // The caller zero-extends its byte address to 32 bits so this helper
    // stays independent of the bus address width.
    function automatic addr_decode_t decode_addr(input logic [31:0] addr,
                                                 input int unsigned num_regs);
        addr_decode_t d;
        d.index = addr[31:2];
        d.err   = (addr[1:0] != 2'b00) || (32'(d.index) >= num_regs);
        return d;
    endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile_if
// AXI4-Lite channel bundle (AW, W, B, AR, R) with a 1-bit response field.
// Clock and reset are not part of the bundle; they stay plain module ports.
//   master modport : drives addresses, data, valids and response readies
//   slave  modport : drives address/data readies, responses and read data
// -----------------------------------------------------------------------------
interface axi_lite_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile_core.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile_core
// Storage for the register bank: NUM_REGS word registers where the last entry
// is a write-transaction counter that only this block updates.
// Ports:
//   s0_axi_aclk / s0_axi_areset : clock, synchronous active-high reset
//   wr_en, wr_idx, wr_data, wr_strb : byte-lane write port; wr_en is only
//                                     raised for accepted (OKAY) writes
//   rd_en, rd_idx, rd_err          : read capture request
//   rd_data                        : registered read data, held between reads
// -----------------------------------------------------------------------------
module axi_lite_regfile_core #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int IDX_W      = 3
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_areset,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        rd_idx,
    input  logic                    rd_err,
    output logic [DATA_WIDTH-1:0]   rd_data
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int CNT_IDX   = NUM_REGS - 1;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // NOTE: sequential state uses non-blocking assignments so that a read
    // captured on the same edge as a write sees the pre-write value.
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            // NOTE: this is a small flop array, not a RAM macro, so every entry
            // is cleared on reset and software can rely on reading zeroes.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                // wr_idx never selects the counter here: the top turns such
                // writes into SLVERR and keeps wr_en low.
                for (int b = 0; b < NUM_LANES; b++) begin
                    if (wr_strb[b]) begin
                        regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
                // Counts every accepted write, even one with no strobes set.
                regs[CNT_IDX] <= regs[CNT_IDX] + DATA_WIDTH'(1);
            end
            if (rd_en) begin
                rd_data <= rd_err ? '0 : regs[rd_idx];
            end
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile
// AXI4-Lite slave register bank. The write channel (AW/W/B) and the read
// channel (AR/R) run independent handshake FSMs; all readies, valids and
// responses come straight from flops.
// Ports:
//   s0_axi_aclk   : clock, rising edge
//   s0_axi_areset : synchronous active-high reset
//   s0_axi        : AXI4-Lite slave bundle (axi_lite_regfile_if.slave)
// -----------------------------------------------------------------------------
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                s0_axi_aclk,
    input  logic                s0_axi_areset,
    axi_lite_regfile_if.slave   s0_axi
);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    w_state_t w_state;
    r_state_t r_state;

    logic                  awready_q, wready_q, bvalid_q, bresp_q;
    logic                  arready_q, rvalid_q, rresp_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit, wr_en, c_err, c_resp;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;
    logic [31:0]           wa_ext, ra_ext;
    addr_decode_t          w_dec, r_dec;
    logic [IDX_W-1:0]      w_idx, r_idx;

    assign aw_hs = awready_q && s0_axi.awvalid;
    assign w_hs  = wready_q  && s0_axi.wvalid;
    assign ar_hs = arready_q && s0_axi.arvalid;

    // Select the commit beat: whichever half arrived earlier comes from the
    // holding registers, the half arriving now comes from the bus.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can infer a latch.
    always_comb begin
        c_addr = (w_state == W_HAVE_AW) ? aw_addr_q : s0_axi.awaddr;
        c_data = (w_state == W_HAVE_W)  ? w_data_q  : s0_axi.wdata;
        c_strb = (w_state == W_HAVE_W)  ? w_strb_q  : s0_axi.wstrb;
        wa_ext = '0;
        wa_ext[ADDR_WIDTH-1:0] = c_addr;
        ra_ext = '0;
        ra_ext[ADDR_WIDTH-1:0] = s0_axi.araddr;
    end

    assign w_dec = decode_addr(wa_ext, NUM_REGS);
    assign r_dec = decode_addr(ra_ext, NUM_REGS);
    assign w_idx = IDX_W'(w_dec.index);
    assign r_idx = IDX_W'(r_dec.index);

    assign commit = ((w_state == W_IDLE)    && aw_hs && w_hs) ||
                    ((w_state == W_HAVE_AW) && w_hs) ||
                    ((w_state == W_HAVE_W)  && aw_hs);

    // The counter register is read-only from the bus.
    assign c_err  = w_dec.err || (32'(w_dec.index) == 32'(NUM_REGS - 1));
    assign c_resp = c_err ? RESP_SLVERR : RESP_OKAY;
    assign wr_en  = commit && !c_err;

    // Write channel FSM
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= c_resp;
                        w_state   <= W_RESP;
                    end else if (aw_hs) begin
                        aw_addr_q <= s0_axi.awaddr;
                        awready_q <= 1'b0;
                        w_state   <= W_HAVE_AW;
                    end else if (w_hs) begin
                        w_data_q <= s0_axi.wdata;
                        w_strb_q <= s0_axi.wstrb;
                        wready_q <= 1'b0;
                        w_state  <= W_HAVE_W;
                    end else begin
                        // Also raises the readies on the first cycle out of reset.
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (w_hs) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= c_resp;
                        w_state  <= W_RESP;
                    end
                end
                W_HAVE_W: begin
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= c_resp;
                        w_state   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s0_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; read data itself is registered inside the core.
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= r_dec.err ? RESP_SLVERR : RESP_OKAY;
                        r_state   <= R_VALID;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_VALID: begin
                    if (s0_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi_lite_regfile_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_core (
        .s0_axi_aclk   (s0_axi_aclk),
        .s0_axi_areset (s0_axi_areset),
        .wr_en         (wr_en),
        .wr_idx        (w_idx),
        .wr_data       (c_data),
        .wr_strb       (c_strb),
        .rd_en         (ar_hs),
        .rd_idx        (r_idx),
        .rd_err        (r_dec.err),
        .rd_data       (s0_axi.rdata)
    );

    assign s0_axi.awready = awready_q;
    assign s0_axi.wready  = wready_q;
    assign s0_axi.bvalid  = bvalid_q;
    assign s0_axi.bresp   = bresp_q;
    assign s0_axi.arready = arready_q;
    assign s0_axi.rvalid  = rvalid_q;
    assign s0_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regfile
// Directed bench for axi_lite_regfile. Write and read expectations are queued
// when a transaction is driven and popped when the response appears.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi_lite_regfile;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_regfile #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR)
    ) dut (
        .s0_axi_aclk   (clk),
        .s0_axi_areset (rst),
        .s0_axi        (bus)
    );

    int total = 0;
    int bad   = 0;

    logic        bexp_q [$];   // expected bresp
    logic [32:0] rexp_q [$];   // expected {rresp, rdata}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold AW and/or W valid until each is accepted, bounded.
    task automatic wait_aw_w();
        logic aw_p, w_p, aw_n, w_n;
        aw_p = bus.awvalid;
        w_p  = bus.wvalid;
        for (int i = 0; i < 20 && (aw_p || w_p); i++) begin
            aw_n = aw_p && bus.awready;
            w_n  = w_p && bus.wready;
            tick();
            if (aw_n) begin bus.awvalid = 1'b0; aw_p = 1'b0; end
            if (w_n)  begin bus.wvalid  = 1'b0; w_p  = 1'b0; end
        end
        check("aw_w_accept_timeout", {aw_p, w_p}, 2'b00);
    endtask

    // Wait for bvalid, compare with the queued response, let bready retire it.
    task automatic get_b(output int lat);
        lat = 0;
        while (!bus.bvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("bvalid_seen", bus.bvalid, 1'b1);
        if (bexp_q.size() != 0) check("bresp", bus.bresp, bexp_q.pop_front());
        tick();
    endtask

    task automatic write_both(input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic er, output int lat);
        bexp_q.push_back(er);
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.wvalid  = 1'b1;
        wait_aw_w();
        get_b(lat);
    endtask

    task automatic read(input logic [7:0] a, input logic [31:0] ed,
                        input logic er, output int lat);
        logic pend, now;
        rexp_q.push_back({er, ed});
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        pend = 1'b1;
        for (int i = 0; i < 20 && pend; i++) begin
            now = bus.arready;
            tick();
            if (now) begin bus.arvalid = 1'b0; pend = 1'b0; end
        end
        check("ar_accept_timeout", pend, 1'b0);
        lat = 0;
        while (!bus.rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("rvalid_seen", bus.rvalid, 1'b1);
        if (rexp_q.size() != 0) check("read_resp_data", {bus.rresp, bus.rdata}, rexp_q.pop_front());
        tick();
    endtask

    initial begin
        int          lat;
        logic        eb;
        logic [32:0] er;

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;

        // ---- reset ----
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl_outputs",
              {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 7'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // ---- same-cycle AW+W ----
        write_both(8'h04, 32'h0000_0017, 4'hF, 1'b0, lat);
        check("first_b_latency", lat, 0);
        read(8'h04, 32'h0000_0017, 1'b0, lat);
        check("read_latency", lat, 0);
        read(8'h1C, 32'd1, 1'b0, lat);

        // ---- W two cycles before AW ----
        bexp_q.push_back(1'b0);
        bus.wdata  = 32'hAABB_CCDD;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("w_first_wready_low", bus.wready, 1'b0);
        check("w_first_awready_high", bus.awready, 1'b1);
        check("w_first_no_bvalid", bus.bvalid, 1'b0);
        tick();
        check("w_first_still_waiting", {bus.wready, bus.bvalid}, 2'b00);
        bus.awaddr  = 8'h10;
        bus.awvalid = 1'b1;
        wait_aw_w();
        get_b(lat);
        check("w_first_b_latency", lat, 0);
        read(8'h10, 32'hAABB_CCDD, 1'b0, lat);

        // ---- partial strobe ----
        write_both(8'h14, 32'hFFFF_FFFF, 4'hF, 1'b0, lat);
        write_both(8'h14, 32'h1122_3344, 4'h5, 1'b0, lat);
        read(8'h14, 32'hFF22_FF44, 1'b0, lat);

        // ---- error cases; counter stays at 4 ----
        write_both(8'h02, 32'h1234_5678, 4'hF, 1'b1, lat);
        write_both(8'h40, 32'h1234_5678, 4'hF, 1'b1, lat);
        write_both(8'h1C, 32'h1234_5678, 4'hF, 1'b1, lat);
        read(8'h40, 32'h0, 1'b1, lat);
        read(8'h1C, 32'd4, 1'b0, lat);

        // ---- backpressure on both response channels ----
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        bexp_q.push_back(1'b0);
        rexp_q.push_back({1'b0, 32'h0000_0017});
        bus.awaddr = 8'h08; bus.awvalid = 1'b1;
        bus.wdata = 32'h5A5A_5A5A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 8'h04; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        eb = bexp_q.pop_front();
        er = rexp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid_bresp", {bus.bvalid, bus.bresp}, {1'b1, eb});
            check("bp_rvalid_r", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, er});
            check("bp_readies_low", {bus.awready, bus.wready, bus.arready}, 3'b000);
            tick();
        end
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        tick();
        check("bp_release_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("bp_release_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        read(8'h08, 32'h5A5A_5A5A, 1'b0, lat);
        read(8'h1C, 32'd5, 1'b0, lat);

        // ---- reset while in W_HAVE_AW and R_VALID ----
        bus.rready = 1'b0;
        bus.awaddr = 8'h00; bus.awvalid = 1'b1;
        bus.araddr = 8'h04; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        check("pre_rst_state", {bus.awready, bus.wready, bus.rvalid}, 3'b011);
        rst = 1'b1;
        bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        check("midop_rst_ctrl",
              {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 7'b0);
        check("midop_rst_rdata", bus.rdata, 32'h0);
        bus.wvalid = 1'b0;
        bus.rready = 1'b1;
        rst = 1'b0;
        bexp_q.delete();
        rexp_q.delete();
        tick();
        check("midop_post_readies", {bus.awready, bus.wready, bus.arready, bus.bvalid}, 4'b1110);
        tick();
        check("midop_no_late_commit", bus.bvalid, 1'b0);
        read(8'h00, 32'h0, 1'b0, lat);
        read(8'h04, 32'h0, 1'b0, lat);
        read(8'h1C, 32'h0, 1'b0, lat);
        write_both(8'h0C, 32'hCAFE_F00D, 4'hF, 1'b0, lat);
        read(8'h0C, 32'hCAFE_F00D, 1'b0, lat);
        read(8'h1C, 32'd1, 1'b0, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
